// File: rtl/median_pkg.sv
// Shared definitions for the median window feeder: FSM states, window size
// and the default pixel width.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int WIN_N = 9;
  localparam int W_DEF = 8;

endpackage

// File: rtl/median_window_feeder_line_buffer.sv
// One raster line of pixels: written on each accepted pixel, read
// combinationally at the same column address (old data is seen before the
// write lands at the clock edge).
module line_buffer
  import median_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int IMG_W = 256,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [IMG_W];

  // Storage is never reset; every entry is rewritten before it is used.
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/median_window_feeder.sv
// Builds 3x3 pixel windows from a raster stream using two line buffers and
// serialises each complete window (9 samples, row-major) to a median stage,
// then waits for the median stage to report completion.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [W-1:0] PIX_IN,
  input  logic         PIX_VAL,
  input  logic         SOF,
  output logic         PIX_RDY,
  input  logic         MED_DONE,
  output logic [W-1:0] DO,
  output logic         DSI
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [3:0]    CNT_LAST = 4'(WIN_N - 1);

  state_t        state, state_d;
  logic [CW-1:0] col, cur_col, col_nx;
  logic [RW-1:0] row, cur_row, row_nx;
  logic [3:0]    cnt, cnt_d;
  logic          dsi_d;
  logic [W-1:0]  do_d;
  logic [W-1:0]  rd0, rd1;
  logic [W-1:0]  win   [WIN_N];
  logic [W-1:0]  win_d [WIN_N];
  logic          xfer, complete;

  assign PIX_RDY = (state == IDLE);
  assign xfer    = PIX_VAL && PIX_RDY;

  // SOF forces the accepted pixel to position (0,0) regardless of counters.
  assign cur_col  = SOF ? '0 : col;
  assign cur_row  = SOF ? '0 : row;
  assign complete = (cur_col >= COL_TWO) && (cur_row >= ROW_TWO);

  // Raster position of the pixel after the one being accepted.
  always_comb begin
    col_nx = cur_col + 1'b1;
    row_nx = cur_row;
    if (cur_col == COL_LAST) begin
      col_nx = '0;
      row_nx = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
    end
  end

  // Line buffer 0 holds the previous line, line buffer 1 the one before it.
  line_buffer #(.W(W), .IMG_W(IMG_W), .AW(CW)) u_lb0 (
    .CLK   (CLK),
    .we    (xfer),
    .addr  (cur_col),
    .wdata (PIX_IN),
    .rdata (rd0)
  );

  line_buffer #(.W(W), .IMG_W(IMG_W), .AW(CW)) u_lb1 (
    .CLK   (CLK),
    .we    (xfer),
    .addr  (cur_col),
    .wdata (rd0),
    .rdata (rd1)
  );

  // Window shifted left one column with the new right column appended.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      win_d[3*k]     = win[3*k+1];
      win_d[3*k + 1] = win[3*k+2];
      win_d[3*k + 2] = '0;
    end
    win_d[2] = rd1;
    win_d[5] = rd0;
    win_d[8] = PIX_IN;
  end

  // Next state, sample index and next values of the registered outputs.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dsi_d   = 1'b0;
    do_d    = DO;
    case (state)
      IDLE: begin
        if (xfer && complete) begin
          state_d = SEND;
          cnt_d   = '0;
          dsi_d   = 1'b1;
          do_d    = win_d[0];
        end
      end
      SEND: begin
        if (cnt == CNT_LAST) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt + 4'd1;
          dsi_d = 1'b1;
          do_d  = win[cnt + 4'd1];
        end
      end
      WAIT: begin
        if (MED_DONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, window snapshot and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      col   <= '0;
      row   <= '0;
      DSI   <= 1'b0;
      DO    <= '0;
      for (int k = 0; k < WIN_N; k++) win[k] <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      DSI   <= dsi_d;
      DO    <= do_d;
      if (xfer) begin
        col <= col_nx;
        row <= row_nx;
        for (int k = 0; k < WIN_N; k++) win[k] <= win_d[k];
      end
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Randomised scoreboard bench for median_window_feeder on a 4x4 image.
module tb_median_window_feeder;

  localparam int W     = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  typedef logic [8:0][W-1:0] win_t;

  logic         CLK = 1'b0;
  logic         nrst;
  logic [W-1:0] pix_in;
  logic         pix_val;
  logic         sof;
  logic         pix_rdy;
  logic         med_done;
  logic [W-1:0] do_s;
  logic         dsi;

  always #5 CLK = ~CLK;

  median_window_feeder #(.W(W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .CLK      (CLK),
    .nRST     (nrst),
    .PIX_IN   (pix_in),
    .PIX_VAL  (pix_val),
    .SOF      (sof),
    .PIX_RDY  (pix_rdy),
    .MED_DONE (med_done),
    .DO       (do_s),
    .DSI      (dsi)
  );

  int compared   = 0;
  int mismatched = 0;

  win_t         exp_q[$];
  win_t         exp_w, cur_win, first_win, fw_exp;
  logic [W-1:0] img [IMG_H][IMG_W];
  int           mr = 0, mc = 0;
  int           run = 0, windows = 0, dsi_cycles = 0;
  logic [W-1:0] last_do = '0;
  int           done_delay = 20;
  bit           rand_delay = 1'b0;
  logic         prev_dsi = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input win_t act, input win_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: track raster position, keep the image, emit windows.
  task automatic model_accept(input logic [W-1:0] p, input logic s);
    int   r, c;
    win_t w;
    r = s ? 0 : mr;
    c = s ? 0 : mc;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) w[k] = img[r - 2 + k / 3][c - 2 + k % 3];
      exp_q.push_back(w);
    end
    c++;
    if (c == IMG_W) begin
      c = 0;
      r = (r == IMG_H - 1) ? 0 : r + 1;
    end
    mr = r;
    mc = c;
  endtask

  task automatic send(input logic [W-1:0] p, input logic s, input int gap);
    int  g = 0;
    bit  ok = 1'b1;
    repeat (gap) @(negedge CLK);
    pix_in  = p;
    sof     = s;
    pix_val = 1'b1;
    while (!pix_rdy) begin
      @(negedge CLK);
      g++;
      if (g > 300) begin
        chk("rdy_timeout", 0, 1);
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      @(posedge CLK);
      model_accept(p, s);
    end
    #1;
    pix_val = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || run != 0 || !pix_rdy) && g < 500) begin
      @(negedge CLK);
      g++;
    end
    chk("drain_timeout", int'(g < 500), 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: collect DSI runs into windows and compare with the scoreboard.
  always @(negedge CLK) begin
    if (!nrst) begin
      run     = 0;
      last_do = '0;
    end else if (dsi) begin
      if (run == 0 && exp_q.size() == 0) chk("unexpected_dsi", 1, 0);
      if (run < 9) cur_win[run] = do_s;
      run++;
      dsi_cycles++;
      last_do = do_s;
      if (run == 9 && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk_win("window", cur_win, exp_w);
        if (windows == 0) first_win = cur_win;
        windows++;
      end
      if (run == 10) chk("dsi_len_over", run, 9);
    end else begin
      if (run != 0) chk("dsi_len", run, 9);
      run = 0;
      chk("do_hold", int'(do_s), int'(last_do));
    end
  end

  // Median-stage stand-in: after each window, wait, then pulse MED_DONE.
  initial begin
    int d;
    med_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (nrst && prev_dsi && !dsi) begin
        d = rand_delay ? int'($urandom_range(0, 3)) : done_delay;
        for (int i = 0; i < d; i++) begin
          chk("rdy_low_in_wait", int'(pix_rdy), 0);
          @(negedge CLK);
        end
        med_done = 1'b1;
        @(negedge CLK);
        med_done = 1'b0;
        chk("rdy_after_done", int'(pix_rdy), 1);
      end
      prev_dsi = dsi;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, g;
    int fw [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    nrst    = 1'b0;
    pix_val = 1'b0;
    sof     = 1'b0;
    pix_in  = '0;

    repeat (3) @(negedge CLK);
    chk("reset_rdy", int'(pix_rdy), 1);
    chk("reset_dsi", int'(dsi), 0);
    chk("reset_do", int'(do_s), 0);
    nrst = 1'b1;
    repeat (30) @(negedge CLK);
    chk("idle_rdy", int'(pix_rdy), 1);
    chk("idle_dsi_cycles", dsi_cycles, 0);
    chk("idle_do", int'(do_s), 0);

    // Frame of 1..16 with long MED_DONE holdoff.
    done_delay = 20;
    for (int i = 1; i <= 16; i++) begin
      send(W'(i), i == 1, 0);
      if (i == 10) chk("border_silent_a", dsi_cycles, 0);
    end
    drain();
    chk("windows_a", windows, 4);
    chk("dsi_cycles_a", dsi_cycles, 36);
    for (int k = 0; k < 9; k++) fw_exp[k] = W'(fw[k]);
    chk_win("first_window", first_win, fw_exp);

    // Random frame with short random holdoff; new SOF restarts border.
    rand_delay = 1'b1;
    w0 = windows;
    d0 = dsi_cycles;
    for (int i = 0; i < 16; i++) begin
      send(W'($urandom), i == 0, int'($urandom_range(0, 2)));
      if (i == 9) chk("border_silent_b", dsi_cycles, d0);
    end
    drain();
    chk("windows_b", windows, w0 + 4);

    // Random stream with a mid-frame SOF resync.
    for (int i = 0; i < 40; i++)
      send(W'($urandom), (i == 0) || (i == 23), int'($urandom_range(0, 1)));
    drain();

    // Reset during the 5th SEND cycle.
    for (int i = 0; i < 11; i++) send(W'($urandom), i == 0, 0);
    g = 0;
    while (run < 5 && g < 100) begin
      @(negedge CLK);
      #2;
      g++;
    end
    chk("send_reached", int'(g < 100), 1);
    nrst = 1'b0;
    #1;
    chk("midreset_dsi", int'(dsi), 0);
    chk("midreset_do", int'(do_s), 0);
    chk("midreset_rdy", int'(pix_rdy), 1);
    exp_q.delete();
    mr = 0;
    mc = 0;
    repeat (3) @(negedge CLK);
    nrst = 1'b1;
    w0 = windows;
    d0 = dsi_cycles;
    for (int i = 0; i < 16; i++) begin
      send(W'($urandom), 1'b0, 0);
      if (i == 9) chk("border_silent_after_reset", dsi_cycles, d0);
    end
    drain();
    chk("windows_after_reset", windows, w0 + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/median_window_feeder.md
MEDIAN_WINDOW_FEEDER -- requirements
Module: median_window_feeder

Interface
REQ-001 Parameter W, default 8: pixel bit width, identical to the downstream median stage.
REQ-002 Parameter IMG_W, default 256: pixels per line, at least 3.
REQ-003 Parameter IMG_H, default 256: lines per frame, at least 3.
REQ-004 CLK  in  1  clock; all logic is rising-edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 PIX_IN  in  W  raster-order input pixel.
REQ-007 PIX_VAL  in  1  PIX_IN valid.
REQ-008 SOF  in  1  start of frame, qualified by PIX_VAL, marks pixel (0,0).
REQ-009 PIX_RDY  out  1  block can accept a pixel; a pixel transfers when PIX_VAL=1 and PIX_RDY=1.
REQ-010 MED_DONE  in  1  result strobe (DSO) from the median stage.
REQ-011 DO  out  W  serial window sample to the median stage (DI).
REQ-012 DSI  out  1  sample strobe to the median stage; held high for exactly 9 consecutive cycles per window.

Function
REQ-013 The FSM SHALL have three states: IDLE, SEND and WAIT.
REQ-014 PIX_RDY SHALL be 1 only in IDLE (combinational decode of state).
REQ-015 On each transfer, the block SHALL shift the 3x3 window left by one column. The new right column SHALL be {line buffer 1[col], line buffer 0[col], PIX_IN}, top to bottom.
REQ-016 On each transfer, line buffer 1[col] SHALL be written with line buffer 0[col], and line buffer 0[col] with PIX_IN.
REQ-017 On each transfer, col SHALL increment and wrap IMG_W-1 to 0. On that wrap, row SHALL increment and wrap IMG_H-1 to 0.
REQ-018 A transfer with SOF=1 SHALL be treated as col=0, row=0, overriding the counters. Counters then continue from (0,1).
REQ-019 A transfer at col>=2 and row>=2 forms a complete window centred on (row-1, col-1). The FSM SHALL go to SEND on the next edge. Any other transfer SHALL leave the FSM in IDLE.
REQ-020 In SEND, DSI SHALL be 1 for 9 cycles. DO SHALL present the window in row-major order, top-left first and bottom-right last, one sample per cycle.
REQ-021 DO and DSI SHALL be registered outputs.
REQ-022 After the 9th sample, the FSM SHALL enter WAIT with DSI=0.
REQ-023 In WAIT, MED_DONE=1 SHALL return the FSM to IDLE on the next edge. MED_DONE SHALL be ignored in IDLE and SEND.
REQ-024 Minimum spacing between complete windows SHALL be 11 cycles: accept, 9 SEND cycles, at least 1 WAIT cycle.
REQ-025 DO SHALL hold its last value when DSI=0.
REQ-026 The window snapshot used for SEND SHALL be frozen at transfer time and SHALL NOT change until the FSM returns to IDLE.
REQ-027 Border pixels (row<2 or col<2) SHALL update the window and line buffers but SHALL produce no DSI activity.

Reset
REQ-028 While nRST=0: state=IDLE, col=0, row=0, DSI=0, DO=0, sample counter=0, window registers=0. PIX_RDY therefore reads 1.
REQ-029 Line buffer contents SHALL NOT be reset; they are always overwritten before first use.
REQ-030 Reset asserted mid-SEND SHALL drop DSI to 0 immediately (asynchronously), and no partial window SHALL be resumed.

Structure
REQ-031 Package median_pkg SHALL hold the state enum (IDLE, SEND, WAIT), the window-size constant 9 and the default W.
REQ-032 Sub-module line_buffer SHALL implement one IMG_W x W single-port, write-on-transfer memory, with read data combinational on address col. It SHALL be instantiated twice.

Verification
REQ-033 Reset check: after nRST release with PIX_VAL=0 -> PIX_RDY=1, DSI=0, DO=0, and DSI stays 0 indefinitely.
REQ-034 Border suppression: IMG_W=4, IMG_H=4; stream pixels 1..16 with SOF on the first -> no DSI during the first 10 transfers.
REQ-035 First window: same stream -> after pixel 11, DO over 9 DSI cycles = 1,2,3,5,6,7,9,10,11.
REQ-036 Handshake: hold MED_DONE=0 for 20 cycles after SEND -> PIX_RDY=0 throughout. MED_DONE pulse -> PIX_RDY=1 on the following cycle.
REQ-037 Window count: a full 4x4 frame -> exactly 4 windows of 9 DSI cycles each. The next SOF frame starts again with 10 silent transfers.
REQ-038 Mid-send reset: nRST low during the 5th SEND cycle -> DSI=0 at once. After release, the first two lines are treated as border again.
